// File: rtl/exe_if.sv
// exe_if: decode bundle into the execute stage and its results toward EXE/MEM
interface exe_if;
  logic [5:0]  stall;
  logic        i_write_mem, i_write_regfile, i_mem_to_regfile, i_jal, i_aluimm, i_shift;
  logic [31:0] i_pc, i_da, i_db, i_imm;
  logic [4:0]  i_rn;
  logic [22:0] i_ALUControl;
  logic [7:0]  i_mem_control;
  logic        o_write_mem, o_mem_to_regfile, o_write_regfile, o_ov, o_stall_req;
  logic [7:0]  o_mem_control;
  logic [4:0]  o_rn;
  logic [31:0] o_result, o_db;
  modport master (
    output stall, i_write_mem, i_write_regfile, i_mem_to_regfile, i_jal, i_aluimm, i_shift,
           i_pc, i_da, i_db, i_imm, i_rn, i_ALUControl, i_mem_control,
    input  o_write_mem, o_mem_to_regfile, o_write_regfile, o_ov, o_stall_req,
           o_mem_control, o_rn, o_result, o_db
  );
  modport slave (
    input  stall, i_write_mem, i_write_regfile, i_mem_to_regfile, i_jal, i_aluimm, i_shift,
           i_pc, i_da, i_db, i_imm, i_rn, i_ALUControl, i_mem_control,
    output o_write_mem, o_mem_to_regfile, o_write_regfile, o_ov, o_stall_req,
           o_mem_control, o_rn, o_result, o_db
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: ALU, multiplier, restoring divider and HI/LO registers of the execute stage
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input logic clk,
  input logic reset,
  exe_if.slave x
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [22:0] c;
  logic [31:0] da, db, opb, sum, dif, sra_v, alu, ua, ub;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, quo_fix, rem_fix;
  logic [63:0] ma, mb, prod;
  logic [32:0] sh;
  logic [33:0] tr;
  logic [4:0]  sa;
  logic [5:0]  cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, div_op, sgn, ov, stall_req, unused;

  assign c      = x.i_ALUControl;
  assign da     = x.i_da;
  assign db     = x.i_db;
  assign opb    = x.i_aluimm ? x.i_imm : db;
  assign sa     = x.i_shift ? x.i_imm[10:6] : da[4:0];
  assign sum    = da + opb;
  assign dif    = da - opb;
  assign sra_v  = $signed(db) >>> sa;
  assign ov     = (c[0] & (da[31] == opb[31]) & (sum[31] != da[31]))
                | (c[2] & (da[31] != opb[31]) & (dif[31] != da[31]));
  assign alu    = ({32{c[0] | c[1]}} & sum) | ({32{c[2] | c[3]}} & dif)
                | ({32{c[4]}} & (da & opb)) | ({32{c[5]}} & (da | opb))
                | ({32{c[6]}} & (da ^ opb)) | ({32{c[7]}} & ~(da | opb))
                | {31'b0, c[8] & ($signed(da) < $signed(opb))} | {31'b0, c[9] & (da < opb)}
                | ({32{c[10]}} & (db << sa)) | ({32{c[11]}} & (db >> sa))
                | ({32{c[12]}} & sra_v) | ({32{c[13]}} & {x.i_imm[15:0], 16'b0})
                | ({32{c[18]}} & hi_q) | ({32{c[19]}} & lo_q);
  // one 64x64 multiplier serves both MULT and MULTU via sign/zero extension
  assign ma     = {(c[14] & da[31]) ? 32'hFFFF_FFFF : 32'h0, da};
  assign mb     = {(c[14] & db[31]) ? 32'hFFFF_FFFF : 32'h0, db};
  assign prod   = ma * mb;
  assign div_op = c[16] | c[17];
  assign sgn    = c[16];
  assign ua     = (sgn & da[31]) ? -da : da;
  assign ub     = (sgn & db[31]) ? -db : db;
  assign sh     = {rem_q, quo_q[31]};
  assign tr     = {1'b0, sh} - {2'b0, dvs_q};
  assign quo_fix = qneg_q ? -quo_q : quo_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;
  assign unused = ^{x.stall[5:4], x.stall[2:0], c[22], tr[32]};

  assign x.o_write_mem      = x.i_write_mem;
  assign x.o_mem_to_regfile = x.i_mem_to_regfile;
  assign x.o_mem_control    = x.i_mem_control;
  assign x.o_rn             = x.i_rn;
  assign x.o_db             = db;
  assign x.o_ov             = ov;
  assign x.o_write_regfile  = x.i_write_regfile & ~ov;
  assign x.o_result         = x.i_jal ? x.i_pc + 32'd8 : alu;
  assign x.o_stall_req      = stall_req;

  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = div_op ? (db == '0 ? DONE : RUN) : IDLE;
      RUN:     state_d = cnt_q == 6'(DIV_CYCLES - 1) ? DONE : RUN;
      DONE:    state_d = x.stall[3] ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb stall_req = (state_q == IDLE && div_op) || state_q == RUN;

  always_comb begin
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (state_q == IDLE && div_op) begin
      cnt_d  = '0;
      quo_d  = ua;
      rem_d  = '0;
      dvs_d  = ub;
      qneg_d = sgn & (da[31] ^ db[31]);
      rneg_d = sgn & da[31];
      dz_d   = db == '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 6'd1;
      rem_d = tr[33] ? sh[31:0] : tr[31:0];
      quo_d = {quo_q[30:0], ~tr[33]};
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!x.stall[3]) begin
      if (state_q == DONE) begin
        hi_d = dz_q ? hi_q : rem_fix;
        lo_d = dz_q ? lo_q : quo_fix;
      end else if (c[14] | c[15]) begin
        {hi_d, lo_d} = prod;
      end else begin
        hi_d = c[20] ? da : hi_q;
        lo_d = c[21] ? da : lo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end
endmodule
